basis_sift_scanner: RTL

- Downstream consumer of the 1024-deep dual-bit sifting store. It scans the stored Alice basis (port A bit) and Bob basis (port B bit) for each raw-key index.
- It emits, over a valid/ready stream, the index of every position where the two bases match, and it counts the matches.
- Its output feeds the sifted-key extraction and error-estimation stages.
- It only reads the store, at up to one index per cycle.

---
 rtl/basis_sift_scanner_pkg.sv | 11 +
 rtl/basis_sift_scanner.sv | 139 +++++++++++++
 2 files changed

// File: rtl/basis_sift_scanner_pkg.sv
// Shared widths and state encoding for the basis sifting scanner.
package basis_sift_scanner_pkg;

  localparam int unsigned SIFT_ADDR_W = 10;
  localparam int unsigned SIFT_CNT_W  = SIFT_ADDR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/basis_sift_scanner.sv
// Scans the dual-bit sifting store and streams out every index whose
// Alice and Bob bases agree, counting the matches.
module basis_sift_scanner
  import basis_sift_scanner_pkg::*;
#(
  parameter int unsigned ADDR_W = SIFT_ADDR_W,
  parameter int unsigned CNT_W  = SIFT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_bits,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_out_a,
  input  logic              mem_out_b,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [ADDR_W-1:0] idx_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              p1_valid_q, p1_valid_d;
  logic [ADDR_W-1:0] p1_idx_q, p1_idx_d;
  logic              idx_valid_q, idx_valid_d;
  logic [ADDR_W-1:0] idx_data_q, idx_data_d;
  logic [CNT_W-1:0]  match_count_q, match_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              adv_c;

  // Pipeline advances unless the output slot is full and not being taken.
  assign adv_c = !(idx_valid_q && !idx_ready);
  // On a stall the store re-reads the pending index so its data stays valid.
  assign mem_addr = adv_c ? next_addr_q : p1_idx_q;
  assign mem_we   = 1'b0;

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    issued_d      = issued_q;
    next_addr_d   = next_addr_q;
    p1_valid_d    = p1_valid_q;
    p1_idx_d      = p1_idx_q;
    idx_valid_d   = idx_valid_q;
    idx_data_d    = idx_data_q;
    match_count_d = match_count_q;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          match_count_d = '0;
          if (num_bits != '0) begin
            num_d       = num_bits;
            issued_d    = '0;
            next_addr_d = '0;
            state_d     = ST_SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SCAN, ST_DRAIN: begin
        if (adv_c) begin
          // Evaluate the index whose store data is visible this cycle.
          if (p1_valid_q && (mem_out_a == mem_out_b)) begin
            idx_valid_d   = 1'b1;
            idx_data_d    = p1_idx_q;
            match_count_d = match_count_q + CNT_W'(1);
          end else begin
            idx_valid_d = 1'b0;
          end
          // Issue the next index; the stop test uses the wide counter so a
          // full-depth scan does not re-issue the wrapped address.
          if (issued_q < num_q) begin
            p1_valid_d  = 1'b1;
            p1_idx_d    = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(1);
            issued_d    = issued_q + CNT_W'(1);
          end else begin
            p1_valid_d = 1'b0;
          end
          if ((state_q == ST_SCAN) && (issued_q == num_q) && p1_valid_q) begin
            state_d = ST_DRAIN;
          end
          if (state_q == ST_DRAIN) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      num_q         <= '0;
      issued_q      <= '0;
      next_addr_q   <= '0;
      p1_valid_q    <= 1'b0;
      p1_idx_q      <= '0;
      idx_valid_q   <= 1'b0;
      idx_data_q    <= '0;
      match_count_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      issued_q      <= issued_d;
      next_addr_q   <= next_addr_d;
      p1_valid_q    <= p1_valid_d;
      p1_idx_q      <= p1_idx_d;
      idx_valid_q   <= idx_valid_d;
      idx_data_q    <= idx_data_d;
      match_count_q <= match_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign idx_valid   = idx_valid_q;
  assign idx_data    = idx_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match_count = match_count_q;

endmodule
